// File: rtl/smi_stream_mux.sv
// SMI stream mux: pulls words from NUM_CH RX FIFOs and shifts them out MSB-first, one byte per SMI read strobe.
// Optional macro SMI_MUX_TAG_EN prefixes each sample with a channel tag byte {1'b1, 4'b0000, ch[2:0]}.
module smi_stream_mux #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 32,
  parameter int CH_W     = 3
) (
  input  logic                       i_sys_clk,
  input  logic                       i_reset,
  input  logic                       i_mode,
  input  logic [CH_W-1:0]            i_ch_sel,
  input  logic [NUM_CH-1:0]          i_fifo_empty,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_fifo_data,
  output logic [NUM_CH-1:0]          o_fifo_pull,
  input  logic                       i_smi_soe_se,
  output logic [7:0]                 o_smi_data,
  output logic                       o_data_valid,
  output logic [CH_W-1:0]            o_cur_ch,
  output logic [15:0]                o_underrun_cnt
);

  localparam int BYTES = SAMPLE_W / 8;
`ifdef SMI_MUX_TAG_EN
  localparam int NBYTES = BYTES + 1;
`else
  localparam int NBYTES = BYTES;
`endif
  localparam int TOT_W = NBYTES * 8;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULL  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                soe_meta_q, soe_meta_d;
  logic                soe_sync_q, soe_sync_d;
  logic                soe_prev_q, soe_prev_d;
  logic [CH_W-1:0]     rr_last_q, rr_last_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [TOT_W-1:0]    shift_q, shift_d;
  logic [3:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          smi_data_q, smi_data_d;
  logic                valid_q, valid_d;
  logic [NUM_CH-1:0]   pull_q, pull_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;

  logic                done_s;
  logic                hi_found_s, lo_found_s;
  logic [CH_W-1:0]     hi_ch_s, lo_ch_s, rr_ch_s, fix_ch_s, sel_ch_s;
  logic                sel_empty_s;
  logic [NUM_CH-1:0]   sel_onehot_s;
  logic [SAMPLE_W-1:0] load_word_s;
  logic [TOT_W-1:0]    load_full_s, shifted_s;

  assign done_s = soe_sync_q & ~soe_prev_q;

  // Channel selection: round-robin searches above the last served channel first, then wraps.
  always_comb begin
    hi_found_s   = 1'b0;
    lo_found_s   = 1'b0;
    hi_ch_s      = '0;
    lo_ch_s      = '0;
    sel_empty_s  = 1'b1;
    sel_onehot_s = '0;
    load_word_s  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!hi_found_s && !i_fifo_empty[k] && (CH_W'(k) > rr_last_q)) begin
        hi_found_s = 1'b1;
        hi_ch_s    = CH_W'(k);
      end else if (!lo_found_s && !i_fifo_empty[k] && (CH_W'(k) <= rr_last_q)) begin
        lo_found_s = 1'b1;
        lo_ch_s    = CH_W'(k);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    rr_ch_s  = hi_found_s ? hi_ch_s : lo_ch_s;
    fix_ch_s = (int'(i_ch_sel) < NUM_CH) ? i_ch_sel : '0;
    sel_ch_s = i_mode ? rr_ch_s : fix_ch_s;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch_s == CH_W'(k)) begin
        sel_empty_s     = i_fifo_empty[k];
        sel_onehot_s[k] = 1'b1;
      end else begin
        sel_onehot_s[k] = 1'b0;
      end
      if (pend_ch_q == CH_W'(k)) begin
        load_word_s = i_fifo_data[k*SAMPLE_W +: SAMPLE_W];
      end else begin
        load_word_s = load_word_s;
      end
    end
`ifdef SMI_MUX_TAG_EN
    load_full_s = {1'b1, 4'b0000, 3'(pend_ch_q), load_word_s};
`else
    load_full_s = load_word_s;
`endif
    shifted_s = shift_q << 4'd8;
  end

  // Next-state logic for the sequencer, synchroniser and underrun counter.
  always_comb begin
    state_d        = state_q;
    soe_meta_d     = i_smi_soe_se;
    soe_sync_d     = soe_meta_q;
    soe_prev_d     = soe_sync_q;
    rr_last_d      = rr_last_q;
    pend_ch_d      = pend_ch_q;
    cur_ch_d       = cur_ch_q;
    shift_d        = shift_q;
    byte_idx_d     = byte_idx_q;
    smi_data_d     = smi_data_q;
    valid_d        = valid_q;
    pull_d         = '0;
    underrun_cnt_d = underrun_cnt_q;

    if (done_s && (state_q != ST_SHIFT) && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end else begin
      underrun_cnt_d = underrun_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!sel_empty_s) begin
          pull_d    = sel_onehot_s;
          pend_ch_d = sel_ch_s;
          rr_last_d = sel_ch_s;
          state_d   = ST_PULL;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_PULL: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d    = load_full_s;
        smi_data_d = load_full_s[TOT_W-1 -: 8];
        valid_d    = 1'b1;
        cur_ch_d   = pend_ch_q;
        byte_idx_d = 4'd0;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (done_s && (byte_idx_q == LAST_IDX)) begin
          valid_d    = 1'b0;
          smi_data_d = 8'h00;
          state_d    = ST_IDLE;
        end else if (done_s) begin
          shift_d    = shifted_s;
          smi_data_d = shifted_s[TOT_W-1 -: 8];
          byte_idx_d = byte_idx_q + 4'd1;
        end else begin
          state_d    = ST_SHIFT;
        end
      end
      default: begin
        valid_d    = 1'b0;
        smi_data_d = 8'h00;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State registers; reset points the round-robin pointer at the last channel so channel 0 is checked first.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      soe_meta_q     <= 1'b1;
      soe_sync_q     <= 1'b1;
      soe_prev_q     <= 1'b1;
      rr_last_q      <= CH_W'(NUM_CH - 1);
      pend_ch_q      <= '0;
      cur_ch_q       <= '0;
      shift_q        <= '0;
      byte_idx_q     <= 4'd0;
      smi_data_q     <= 8'h00;
      valid_q        <= 1'b0;
      pull_q         <= '0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      soe_meta_q     <= soe_meta_d;
      soe_sync_q     <= soe_sync_d;
      soe_prev_q     <= soe_prev_d;
      rr_last_q      <= rr_last_d;
      pend_ch_q      <= pend_ch_d;
      cur_ch_q       <= cur_ch_d;
      shift_q        <= shift_d;
      byte_idx_q     <= byte_idx_d;
      smi_data_q     <= smi_data_d;
      valid_q        <= valid_d;
      pull_q         <= pull_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign o_fifo_pull    = pull_q;
  assign o_smi_data     = smi_data_q;
  assign o_data_valid   = valid_q;
  assign o_cur_ch       = cur_ch_q;
  assign o_underrun_cnt = underrun_cnt_q;

endmodule
